// File: rtl/fifo_sync.sv
// Single-clock FIFO with standard or first-word-fall-through read, registered
// status flags consistent with data_count, and per-operation status pulses.
module fifo_sync #(
  parameter int FIFO_DEPTH        = 16,
  parameter int DATA_WIDTH        = 32,
  parameter int READ_MODE_FWFT    = 0,
  parameter int PROG_FULL_THRESH  = 12,
  parameter int PROG_EMPTY_THRESH = 4,
  parameter int CW                = $clog2(FIFO_DEPTH) + 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  flush,
  input  logic [DATA_WIDTH-1:0] din,
  input  logic                  wr_en,
  input  logic                  rd_en,
  output logic [DATA_WIDTH-1:0] dout,
  output logic                  full,
  output logic                  almost_full,
  output logic                  prog_full,
  output logic                  empty,
  output logic                  almost_empty,
  output logic                  prog_empty,
  output logic                  wr_ack,
  output logic                  overflow,
  output logic                  data_valid,
  output logic                  underflow,
  output logic [CW-1:0]         data_count
);

  localparam int              PW      = $clog2(FIFO_DEPTH);
  localparam bit              FWFT    = (READ_MODE_FWFT != 0);
  localparam logic [CW-1:0]   CNT_ONE = CW'(1);
  localparam logic [PW-1:0]   PTR_ONE = PW'(1);

  // Returns {full, almost_full, prog_full, empty, almost_empty, prog_empty}.
  function automatic logic [5:0] flags_of(input logic [CW-1:0] cnt, input logic stage_vld);
    logic [5:0] f;
    f[5] = (cnt == CW'(FIFO_DEPTH));
    f[4] = (cnt >= CW'(FIFO_DEPTH - 1));
    f[3] = (cnt >= CW'(PROG_FULL_THRESH));
    f[2] = FWFT ? !stage_vld : (cnt == '0);
    f[1] = (cnt <= CNT_ONE);
    f[0] = (cnt <= CW'(PROG_EMPTY_THRESH));
    return f;
  endfunction

  logic [DATA_WIDTH-1:0] mem [FIFO_DEPTH];
  logic [PW-1:0]         wr_ptr;
  logic [PW-1:0]         rd_ptr;
  logic                  wr_acc;
  logic                  rd_acc;
  logic                  fetch;
  logic                  rd_adv;
  logic [CW-1:0]         count_nxt;
  logic [CW-1:0]         vis_cnt;
  logic [CW-1:0]         vis_nxt;
  logic                  wr_vld_p0;
  logic                  vld_p1;
  logic                  vld_p1_nxt;
  logic [5:0]            flags_nxt;

  assign wr_acc = wr_en & ~full & ~flush;
  assign rd_acc = rd_en & ~empty & ~flush;

  // FWFT prefetch only sees words whose write landed at least one edge earlier,
  // which places a word on dout two edges after it was written.
  assign fetch  = FWFT & ~flush & (vis_cnt != '0) & (~vld_p1 | rd_acc);
  assign rd_adv = FWFT ? fetch : rd_acc;

  always_comb begin
    count_nxt = data_count;
    if (flush)
      count_nxt = '0;
    else if (wr_acc && !rd_acc)
      count_nxt = data_count + CNT_ONE;
    else if (!wr_acc && rd_acc)
      count_nxt = data_count - CNT_ONE;

    vis_nxt = vis_cnt;
    if (flush)
      vis_nxt = '0;
    else if (wr_vld_p0 && !fetch)
      vis_nxt = vis_cnt + CNT_ONE;
    else if (!wr_vld_p0 && fetch)
      vis_nxt = vis_cnt - CNT_ONE;

    vld_p1_nxt = vld_p1;
    if (flush)
      vld_p1_nxt = 1'b0;
    else if (fetch)
      vld_p1_nxt = 1'b1;
    else if (rd_acc)
      vld_p1_nxt = 1'b0;

    flags_nxt = flags_of(count_nxt, vld_p1_nxt);
  end

  // stage p0: memory write
  always_ff @(posedge clk) begin
    if (wr_acc)
      mem[wr_ptr] <= din;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      data_count   <= '0;
      vis_cnt      <= '0;
      wr_vld_p0    <= 1'b0;
      vld_p1       <= 1'b0;
      full         <= 1'b0;
      almost_full  <= 1'b0;
      prog_full    <= 1'b0;
      empty        <= 1'b1;
      almost_empty <= 1'b1;
      prog_empty   <= 1'b1;
      wr_ack       <= 1'b0;
      overflow     <= 1'b0;
      underflow    <= 1'b0;
      data_valid   <= 1'b0;
    end else begin
      wr_ptr       <= flush ? '0 : (wr_acc ? wr_ptr + PTR_ONE : wr_ptr);
      rd_ptr       <= flush ? '0 : (rd_adv ? rd_ptr + PTR_ONE : rd_ptr);
      data_count   <= count_nxt;
      vis_cnt      <= vis_nxt;
      wr_vld_p0    <= wr_acc;
      vld_p1       <= vld_p1_nxt;
      full         <= flags_nxt[5];
      almost_full  <= flags_nxt[4];
      prog_full    <= flags_nxt[3];
      empty        <= flags_nxt[2];
      almost_empty <= flags_nxt[1];
      prog_empty   <= flags_nxt[0];
      wr_ack       <= wr_acc;
      overflow     <= wr_en & full & ~flush;
      underflow    <= rd_en & empty & ~flush;
      data_valid   <= FWFT ? ~flags_nxt[2] : rd_acc;
    end
  end

  // stage p1: registered read port / FWFT output stage
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      dout <= '0;
    else if (FWFT && flush)
      dout <= '0;
    else if (rd_adv)
      dout <= mem[rd_ptr];
  end

endmodule

// File: tb/tb_fifo_sync.sv
// Randomized scoreboard bench for fifo_sync: a standard-mode and an FWFT-mode
// instance share stimulus and are checked against queue-based reference models.
module tb_fifo_sync;

  localparam int D = 16;
  localparam int W = 32;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         flush;
  logic         wr_en;
  logic         rd_en;
  logic [W-1:0] din;

  logic [W-1:0] s_dout, f_dout;
  logic s_full, s_afull, s_pfull, s_empty, s_aempty, s_pempty;
  logic s_wr_ack, s_ovf, s_dv, s_udf;
  logic f_full, f_afull, f_pfull, f_empty, f_aempty, f_pempty;
  logic f_wr_ack, f_ovf, f_dv, f_udf;
  logic [4:0] s_cnt, f_cnt;

  fifo_sync #(.FIFO_DEPTH(D), .DATA_WIDTH(W), .READ_MODE_FWFT(0),
              .PROG_FULL_THRESH(12), .PROG_EMPTY_THRESH(4)) u_std (
    .clk(clk), .rst_n(rst_n), .flush(flush), .din(din), .wr_en(wr_en), .rd_en(rd_en),
    .dout(s_dout), .full(s_full), .almost_full(s_afull), .prog_full(s_pfull),
    .empty(s_empty), .almost_empty(s_aempty), .prog_empty(s_pempty),
    .wr_ack(s_wr_ack), .overflow(s_ovf), .data_valid(s_dv), .underflow(s_udf),
    .data_count(s_cnt));

  fifo_sync #(.FIFO_DEPTH(D), .DATA_WIDTH(W), .READ_MODE_FWFT(1),
              .PROG_FULL_THRESH(12), .PROG_EMPTY_THRESH(4)) u_fwft (
    .clk(clk), .rst_n(rst_n), .flush(flush), .din(din), .wr_en(wr_en), .rd_en(rd_en),
    .dout(f_dout), .full(f_full), .almost_full(f_afull), .prog_full(f_pfull),
    .empty(f_empty), .almost_empty(f_aempty), .prog_empty(f_pempty),
    .wr_ack(f_wr_ack), .overflow(f_ovf), .data_valid(f_dv), .underflow(f_udf),
    .data_count(f_cnt));

  always #5 clk = ~clk;

  typedef struct { logic [W-1:0] d; int t; } ent_t;

  int           n_cmp = 0;
  int           n_err = 0;
  int           edge_no = 0;
  logic [W-1:0] s_q[$];
  ent_t         f_q[$];
  bit           f_stage;
  logic [W-1:0] s_sb[$];
  logic [W-1:0] f_sb[$];
  logic [W-1:0] s_last;
  bit s_x_ack, s_x_ovf, s_x_udf, s_x_dv;
  bit f_x_ack, f_x_ovf, f_x_udf;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic chk_flags(input string p, input int n, input logic [4:0] cnt,
                           input logic fu, input logic af, input logic pf,
                           input logic ae, input logic pe);
    chk({p, "count"}, cnt, n);
    chk({p, "full"}, fu, n == D);
    chk({p, "almost_full"}, af, n >= D - 1);
    chk({p, "prog_full"}, pf, n >= 12);
    chk({p, "almost_empty"}, ae, n <= 1);
    chk({p, "prog_empty"}, pe, n <= 4);
  endtask

  task automatic model_reset();
    s_q.delete(); f_q.delete(); s_sb.delete(); f_sb.delete();
    f_stage = 0; s_last = '0;
    s_x_ack = 0; s_x_ovf = 0; s_x_udf = 0; s_x_dv = 0;
    f_x_ack = 0; f_x_ovf = 0; f_x_udf = 0;
  endtask

  // Reference behaviour for one clock edge using the inputs just sampled.
  task automatic model_edge();
    int  n;
    bit  aw, ar;
    edge_no++;
    n  = s_q.size();
    aw = wr_en && !flush && n < D;
    ar = rd_en && !flush && n > 0;
    s_x_ack = aw;
    s_x_ovf = wr_en && !flush && n == D;
    s_x_udf = rd_en && !flush && n == 0;
    s_x_dv  = ar;
    if (flush) s_q.delete();
    else begin
      if (ar) s_sb.push_back(s_q.pop_front());
      if (aw) s_q.push_back(din);
    end

    n  = f_q.size();
    aw = wr_en && !flush && n < D;
    ar = rd_en && !flush && f_stage;
    f_x_ack = aw;
    f_x_ovf = wr_en && !flush && n == D;
    f_x_udf = rd_en && !flush && !f_stage;
    if (flush) begin
      f_q.delete(); f_sb.delete(); f_stage = 0;
    end else begin
      if (ar) begin f_q.delete(0); f_stage = 0; end
      if (!f_stage && f_q.size() > 0 && f_q[0].t <= edge_no - 2) f_stage = 1;
      if (aw) begin
        f_q.push_back('{d: din, t: edge_no});
        f_sb.push_back(din);
      end
    end
  endtask

  task automatic step(input logic w, input logic r, input logic f, input logic [W-1:0] d);
    wr_en = w; rd_en = r; flush = f; din = d;
    @(posedge clk);
    model_edge();
    #1;
  endtask

  always @(negedge clk) begin
    logic [W-1:0] e;
    chk_flags("s_", s_q.size(), s_cnt, s_full, s_afull, s_pfull, s_aempty, s_pempty);
    chk_flags("f_", f_q.size(), f_cnt, f_full, f_afull, f_pfull, f_aempty, f_pempty);
    chk("s_empty", s_empty, s_q.size() == 0);
    chk("f_empty", f_empty, !f_stage);
    chk("f_data_valid", f_dv, f_stage);
    chk("s_data_valid", s_dv, s_x_dv);
    chk("s_wr_ack", s_wr_ack, s_x_ack);
    chk("s_overflow", s_ovf, s_x_ovf);
    chk("s_underflow", s_udf, s_x_udf);
    chk("f_wr_ack", f_wr_ack, f_x_ack);
    chk("f_overflow", f_ovf, f_x_ovf);
    chk("f_underflow", f_udf, f_x_udf);
    if (s_dv === 1'b1) begin
      if (s_sb.size() == 0) begin
        n_cmp++; n_err++;
        $display("FAIL s_scoreboard: data_valid with no word expected, dout=%0h", s_dout);
      end else begin
        e = s_sb.pop_front();
        chk("s_dout", s_dout, e);
        s_last = e;
      end
    end else begin
      chk("s_dout_hold", s_dout, s_last);
    end
    if (rst_n && rd_en && !flush && f_empty === 1'b0) begin
      if (f_sb.size() == 0) begin
        n_cmp++; n_err++;
        $display("FAIL f_scoreboard: head presented with no word expected, dout=%0h", f_dout);
      end else begin
        e = f_sb.pop_front();
        chk("f_dout", f_dout, e);
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: run still active at %0t, limit 500000", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0; flush = 1'b0; wr_en = 1'b0; rd_en = 1'b0; din = '0;
    model_reset();
    #1;
    chk("rst_s_dout", s_dout, 0);
    chk("rst_f_dout", f_dout, 0);
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;

    // sequential fill, overflow on the 17th word, ordered drain, underflow
    for (int i = 0; i < 16; i++) step(1, 0, 0, i);
    step(1, 0, 0, 32'h99);
    for (int i = 0; i < 16; i++) step(0, 1, 0, 0);
    step(0, 1, 0, 0);
    step(0, 0, 0, 0);

    // single word fall-through
    step(1, 0, 0, 32'hA5);
    repeat (3) step(0, 0, 0, 0);
    step(0, 1, 0, 0);
    step(0, 0, 0, 0);

    // simultaneous read/write at full and at empty
    for (int i = 0; i < 16; i++) step(1, 0, 0, $urandom());
    repeat (2) step(0, 0, 0, 0);
    step(1, 1, 0, $urandom());
    for (int i = 0; i < 18; i++) step(0, 1, 0, 0);
    step(1, 1, 0, $urandom());
    repeat (3) step(0, 0, 0, 0);
    step(0, 1, 0, 0);

    // flush with a concurrent write, then traffic across the pointer wrap
    for (int i = 0; i < 10; i++) step(1, 0, 0, $urandom());
    step(1, 0, 1, $urandom());
    for (int i = 0; i < 40; i++)
      step($urandom_range(0, 9) < 7, $urandom_range(0, 9) < 6, 0, $urandom());

    // random phases alternating fill-heavy and drain-heavy traffic
    for (int p = 0; p < 6; p++)
      for (int i = 0; i < 60; i++)
        step($urandom_range(0, 99) < ((p % 2 == 0) ? 80 : 25),
             $urandom_range(0, 99) < ((p % 2 == 0) ? 25 : 80),
             $urandom_range(0, 99) == 0, $urandom());

    // asynchronous reset in the middle of a burst at count 9
    for (int i = 0; i < 20; i++) step(0, 1, 0, 0);
    for (int i = 0; i < 9; i++) step(1, 0, 0, $urandom());
    #2;
    rst_n = 1'b0; wr_en = 1'b0; rd_en = 1'b0; flush = 1'b0;
    model_reset();
    #1;
    chk("arst_s_count", s_cnt, 0);
    chk("arst_f_count", f_cnt, 0);
    chk("arst_s_empty", s_empty, 1);
    chk("arst_f_empty", f_empty, 1);
    chk("arst_s_full_flags", {s_full, s_afull, s_pfull}, 0);
    chk("arst_s_dout", s_dout, 0);
    chk("arst_f_dout", f_dout, 0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    for (int i = 0; i < 5; i++) step(1, 0, 0, 32'h1000 + i);
    repeat (2) step(0, 0, 0, 0);
    for (int i = 0; i < 7; i++) step(0, 1, 0, 0);
    repeat (2) step(0, 0, 0, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
